// File: rtl/mem_arbiter_2_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Holds the FSM state encoding, the wait/abort counter width and the default error word.
package mem_arbiter_2_pkg;

  localparam int          CNT_W             = 8;
  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  // Saturating increment used by the abort counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_2_rr_pick.sv
// Combinational two-way round-robin selector.
// With both requests pending, the requester that was not granted last wins.
module mem_rr_pick (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_grant,
  output logic o_any
);

  assign o_any   = i_valid0 | i_valid1;
  assign o_grant = (i_valid0 & i_valid1) ? ~i_last_grant : i_valid1;

endmodule

// File: rtl/mem_arbiter_2.sv
// Two-requester arbiter onto a single valid/ready memory port, one transaction in flight,
// with a downstream timeout that completes the requester with an error word.
module mem_arbiter_2
  import mem_arbiter_2_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_valid,
  input  logic             m0_instr,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  input  logic [3:0]       m0_wstrb,
  output logic             m0_ready,
  output logic [31:0]      m0_rdata,
  input  logic             m1_valid,
  input  logic             m1_instr,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  input  logic [3:0]       m1_wstrb,
  output logic             m1_ready,
  output logic [31:0]      m1_rdata,
  output logic             mem_valid,
  output logic             mem_instr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata,
  output logic             err_pulse,
  output logic             err_grant,
  output logic [CNT_W-1:0] err_count
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_grant;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_err_count;
  logic             r_instr;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic             w_pick;
  logic             w_any;
  logic             w_terminal;
  logic             w_done;
  logic [31:0]      w_rdata;

  mem_rr_pick u_pick (
    .i_valid0    (m0_valid),
    .i_valid1    (m1_valid),
    .i_last_grant(r_last_grant),
    .o_grant     (w_pick),
    .o_any       (w_any)
  );

  // Terminal-count cycle: the BUSY cycle whose miss would bring the counter to TIMEOUT_CYCLES.
  assign w_terminal = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_next = ST_BUSY;
      ST_BUSY: begin
        if (mem_ready)       w_state_next = ST_IDLE;
        else if (w_terminal) w_state_next = ST_ABORT;
      end
      ST_ABORT: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_err_count  <= '0;
      r_instr      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
        r_cnt        <= '0;
        r_instr      <= w_pick ? m1_instr : m0_instr;
        r_addr       <= w_pick ? m1_addr  : m0_addr;
        r_wdata      <= w_pick ? m1_wdata : m0_wdata;
        r_wstrb      <= w_pick ? m1_wstrb : m0_wstrb;
      end else if (r_state == ST_BUSY && !mem_ready) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Count the abort as it is entered so err_count already reflects it in the ABORT cycle.
      if (r_state == ST_BUSY && !mem_ready && w_terminal) begin
        r_err_count <= sat_inc(r_err_count);
      end
    end
  end

  always_comb begin
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    err_pulse = 1'b0;
    err_grant = 1'b0;
    w_done    = 1'b0;
    w_rdata   = '0;
    case (r_state)
      ST_BUSY: begin
        mem_valid = 1'b1;
        mem_instr = r_instr;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        mem_wstrb = r_wstrb;
        if (mem_ready) begin
          w_done  = 1'b1;
          w_rdata = mem_rdata;
        end
      end
      ST_ABORT: begin
        w_done    = 1'b1;
        w_rdata   = ERR_RDATA;
        err_pulse = 1'b1;
        err_grant = r_grant;
      end
      default: ;
    endcase
    m0_ready = w_done & ~r_grant;
    m1_ready = w_done & r_grant;
    m0_rdata = m0_ready ? w_rdata : '0;
    m1_rdata = m1_ready ? w_rdata : '0;
  end

  assign err_count = r_err_count;

endmodule

// File: tb/tb_mem_arbiter_2.sv
// Self-checking bench for mem_arbiter_2: a scoreboard of expected completions
// is filled as requests are issued and drained by a monitor watching the ready strobes.
module tb_mem_arbiter_2;

  logic        clk;
  logic        reset;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        err_pulse, err_grant;
  logic [7:0]  err_count;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_2 #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .err_pulse(err_pulse), .err_grant(err_grant), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: every ready strobe must match the oldest expected completion.
  always @(negedge clk) begin
    if (!reset) begin
      if (m0_ready || m1_ready) begin
        checks++;
        if (m0_ready && m1_ready) begin
          errors++;
          $display("FAIL both_ready m0_ready=%0b m1_ready=%0b required one-hot", m0_ready, m1_ready);
        end else if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready m0_ready=%0b m1_ready=%0b required no strobe", m0_ready, m1_ready);
        end else begin
          mon_e = sb.pop_front();
          if (m1_ready !== mon_e.port || (m1_ready ? m1_rdata : m0_rdata) !== mon_e.rdata) begin
            errors++;
            $display("FAIL completion got port=%0d rdata=%h required port=%0d rdata=%h",
                     m1_ready, m1_ready ? m1_rdata : m0_rdata, mon_e.port, mon_e.rdata);
          end else begin
            $display("TXN port=%0d rdata=%h", mon_e.port, mon_e.rdata);
          end
        end
      end
      if ((!m0_ready && m0_rdata !== 32'h0) || (!m1_ready && m1_rdata !== 32'h0)) begin
        checks++;
        errors++;
        $display("FAIL idle_rdata got m0=%h m1=%h required 0 while not ready", m0_rdata, m1_rdata);
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_valid, m0_ready, m1_ready, err_pulse, err_grant} !== 5'b0 || err_count !== 8'd0 ||
        mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%0b rdy=%0b%0b err=%0b%0b cnt=%0d addr=%h required all 0",
               mem_valid, m0_ready, m1_ready, err_pulse, err_grant, err_count, mem_addr);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_read();
    m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'b0; m0_instr = 1'b1;
    sb.push_back('{port: 1'b0, rdata: 32'h1234_5678});
    tick();
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h10 || mem_wstrb !== 4'b0 || mem_instr !== 1'b1) begin
      errors++;
      $display("FAIL read_req got valid=%0b addr=%h wstrb=%b instr=%0b required 1 00000010 0000 1",
               mem_valid, mem_addr, mem_wstrb, mem_instr);
    end
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_ready got m0=%0b m1=%0b required 1 0", m0_ready, m1_ready);
    end
    tick();
    mem_ready = 1'b0; m0_valid = 1'b0; m0_instr = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_idle got mem_valid=%0b required 0", mem_valid);
    end
  endtask

  task automatic test_contention();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'b0;
    m1_valid = 1'b1; m1_addr = 32'h200; m1_wstrb = 4'b0;
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{port: 1'(k % 2), rdata: 32'hA000_0000 + 32'(k)});
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_ready = 1'b1; mem_rdata = 32'hA000_0000 + 32'(k);
      @(negedge clk);
      checks++;
      if (mem_addr !== ((k % 2 == 0) ? 32'h100 : 32'h200) || m1_ready !== 1'(k % 2)) begin
        errors++;
        $display("FAIL contention_%0d got addr=%h m1_ready=%0b required addr=%h m1_ready=%0d",
                 k, mem_addr, m1_ready, (k % 2 == 0) ? 32'h100 : 32'h200, k % 2);
      end
      tick();
      mem_ready = 1'b0;
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
  endtask

  task automatic test_write();
    m1_valid = 1'b1; m1_addr = 32'h3FC; m1_wdata = 32'h55; m1_wstrb = 4'b0001;
    sb.push_back('{port: 1'b1, rdata: 32'h0});
    mem_rdata = 32'h0;
    tick();
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        m1_wdata = 32'hFFFF_FFFF; m1_addr = 32'h0; m1_wstrb = 4'b1111;
      end
      if (c == 2) mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h3FC || mem_wdata !== 32'h55 || mem_wstrb !== 4'b0001) begin
        errors++;
        $display("FAIL write_hold_%0d got valid=%0b addr=%h wdata=%h wstrb=%b required 1 000003fc 00000055 0001",
                 c, mem_valid, mem_addr, mem_wdata, mem_wstrb);
      end
      tick();
    end
    mem_ready = 1'b0; m1_valid = 1'b0; m1_wstrb = 4'b0;
  endtask

  task automatic test_timeout();
    m0_valid = 1'b1; m0_addr = 32'h20; m0_wstrb = 4'b0;
    sb.push_back('{port: 1'b0, rdata: 32'hDEAD_BEEF});
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1 || err_pulse !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait_%0d got mem_valid=%0b err_pulse=%0b required 1 0", c, mem_valid, err_pulse);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0 || err_pulse !== 1'b1 || err_grant !== 1'b0 || m0_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort got mem_valid=%0b err_pulse=%0b err_grant=%0b m0_ready=%0b required 0 1 0 1",
               mem_valid, err_pulse, err_grant, m0_ready);
    end
    m0_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (err_pulse !== 1'b0 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL timeout_after got err_pulse=%0b err_count=%0d required 0 1", err_pulse, err_count);
    end
  endtask

  task automatic test_terminal_count();
    m1_valid = 1'b1; m1_addr = 32'h44;
    sb.push_back('{port: 1'b1, rdata: 32'hC0DE_0004});
    tick();
    repeat (3) tick();
    mem_ready = 1'b1; mem_rdata = 32'hC0DE_0004;
    @(negedge clk);
    checks++;
    if (m1_ready !== 1'b1 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL terminal_ready got m1_ready=%0b err_pulse=%0b required 1 0", m1_ready, err_pulse);
    end
    tick();
    mem_ready = 1'b0; m1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err_pulse !== 1'b0 || err_count !== 8'd1 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL terminal_after got err_pulse=%0b err_count=%0d mem_valid=%0b required 0 1 0",
               err_pulse, err_count, mem_valid);
    end
  endtask

  task automatic test_reset_mid();
    m0_valid = 1'b1; m0_addr = 32'h80;
    tick();
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got mem_valid=%0b required 1", mem_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || mem_addr !== 32'h0 || m0_ready !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got mem_valid=%0b addr=%h m0_ready=%0b err_count=%0d required 0 0 0 0",
               mem_valid, mem_addr, m0_ready, err_count);
    end
    m0_valid = 1'b0;
    tick();
    reset = 1'b0;
    m1_valid = 1'b1; m1_addr = 32'h90;
    sb.push_back('{port: 1'b1, rdata: 32'h0BAD_F00D});
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    checks++;
    if (m1_ready !== 1'b1 || mem_addr !== 32'h90) begin
      errors++;
      $display("FAIL post_reset got m1_ready=%0b addr=%h required 1 00000090", m1_ready, mem_addr);
    end
    tick();
    mem_ready = 1'b0; m1_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_read();
    test_contention();
    test_write();
    test_timeout();
    test_terminal_count();
    test_reset_mid();
    repeat (2) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

endmodule
